// File: rtl/edid_update_ctrl_if.sv
// Bus bundle for the EDID update controller: I2C slave side, host update port
// and the shared EDID RAM port.
interface edid_update_ctrl_if;
   logic       i2c_busy;
   logic [7:0] i2c_addr;
   logic [7:0] i2c_wdata;
   logic       i2c_we;
   logic [7:0] i2c_rdata;

   logic       host_req;
   logic       host_grant;
   logic       host_we;
   logic [8:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_done;
   logic       upd_busy;

   logic       ram_we;
   logic [8:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;

   modport slave (
      input  i2c_busy, i2c_addr, i2c_wdata, i2c_we,
      input  host_req, host_we, host_addr, host_wdata, host_done,
      input  ram_rdata,
      output i2c_rdata, host_grant, upd_busy,
      output ram_we, ram_addr, ram_wdata
   );

   modport master (
      output i2c_busy, i2c_addr, i2c_wdata, i2c_we,
      output host_req, host_we, host_addr, host_wdata, host_done,
      output ram_rdata,
      input  i2c_rdata, host_grant, upd_busy,
      input  ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/edid_update_ctrl.sv
// EDID update controller: arbitrates the EDID RAM between the I2C slave and a
// host updater, rewrites block checksums after an update and sequences HPD.
module edid_update_ctrl #(
   parameter logic [31:0] HPD_TIMEOUT_COUNT = 32'd50000000,
   parameter logic [31:0] HPD_LOW_CYCLES    = 32'd5000000,
   parameter int          NUM_BLOCKS        = 2,
   parameter bit          I2C_WR_EN         = 1'b0
) (
   input  logic              cfg_clk,
   input  logic              rst_n,
   input  logic              hdmi_rx_5v_n,
   output logic              hpd,
   edid_update_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DROP = 3'd1,
      HOST = 3'd2,
      CSUM = 3'd3,
      HOLD = 3'd4
   } state_t;

   localparam logic [7:0] IDX_WRITE = 8'd128;
   localparam logic       LAST_BLK  = (NUM_BLOCKS > 1) ? 1'b1 : 1'b0;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_cnt5v;
   logic [31:0] w_cnt5v_nxt;
   logic        r_hpd;
   logic [7:0]  r_idx;
   logic [7:0]  w_idx_nxt;
   logic        r_blk;
   logic        w_blk_nxt;
   logic [7:0]  r_sum;
   logic [7:0]  w_sum_nxt;
   logic [31:0] r_hold;
   logic [31:0] w_hold_nxt;

   logic        w_ram_we;
   logic [8:0]  w_ram_addr;
   logic [7:0]  w_ram_wdata;
   logic [7:0]  w_i2c_rdata;
   logic        w_host_grant;

   // 5V presence counter runs regardless of the update sequence
   always_comb begin
      if (hdmi_rx_5v_n)
         w_cnt5v_nxt = '0;
      else if (r_cnt5v == HPD_TIMEOUT_COUNT)
         w_cnt5v_nxt = r_cnt5v;
      else
         w_cnt5v_nxt = r_cnt5v + 32'd1;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_blk_nxt    = r_blk;
      w_sum_nxt    = r_sum;
      w_hold_nxt   = r_hold;
      w_ram_we     = 1'b0;
      w_ram_addr   = '0;
      w_ram_wdata  = '0;
      w_i2c_rdata  = 8'hFF;
      w_host_grant = 1'b0;

      case (r_state)
         IDLE: begin
            w_ram_addr  = {1'b0, bus.i2c_addr};
            w_ram_we    = bus.i2c_we & I2C_WR_EN;
            w_ram_wdata = bus.i2c_wdata;
            w_i2c_rdata = bus.ram_rdata;
            if (bus.host_req)
               w_state_nxt = DROP;
         end

         DROP: begin
            if (!bus.i2c_busy)
               w_state_nxt = HOST;
         end

         HOST: begin
            w_host_grant = 1'b1;
            w_ram_we     = bus.host_we;
            w_ram_addr   = bus.host_addr;
            w_ram_wdata  = bus.host_wdata;
            if (bus.host_done) begin
               w_state_nxt = CSUM;
               w_idx_nxt   = '0;
               w_blk_nxt   = 1'b0;
               w_sum_nxt   = '0;
            end
         end

         // idx 0..126 read, 127 drains the last read, 128 writes the checksum
         CSUM: begin
            if (r_idx == IDX_WRITE) begin
               w_ram_we    = 1'b1;
               w_ram_addr  = {1'b0, r_blk, 7'h7F};
               w_ram_wdata = 8'd0 - r_sum;
               w_idx_nxt   = '0;
               w_sum_nxt   = '0;
               if (r_blk == LAST_BLK) begin
                  w_state_nxt = HOLD;
                  w_hold_nxt  = '0;
               end else begin
                  w_blk_nxt = r_blk + 1'b1;
               end
            end else begin
               w_ram_addr = {1'b0, r_blk, r_idx[6:0]};
               w_idx_nxt  = r_idx + 8'd1;
               w_sum_nxt  = (r_idx == 8'd0) ? 8'd0 : r_sum + bus.ram_rdata;
            end
         end

         HOLD: begin
            if (r_hold + 32'd1 >= HPD_LOW_CYCLES)
               w_state_nxt = IDLE;
            else
               w_hold_nxt = r_hold + 32'd1;
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge cfg_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt5v <= '0;
         r_hpd   <= 1'b0;
         r_idx   <= '0;
         r_blk   <= 1'b0;
         r_sum   <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt5v <= w_cnt5v_nxt;
         r_hpd   <= (w_state_nxt == IDLE) && (w_cnt5v_nxt == HPD_TIMEOUT_COUNT);
         r_idx   <= w_idx_nxt;
         r_blk   <= w_blk_nxt;
         r_sum   <= w_sum_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   // RAM port is a live mux; forcing it low under reset keeps it quiet immediately
   assign hpd            = r_hpd;
   assign bus.host_grant = w_host_grant;
   assign bus.upd_busy   = (r_state != IDLE);
   assign bus.i2c_rdata  = w_i2c_rdata;
   assign bus.ram_we     = rst_n & w_ram_we;
   assign bus.ram_addr   = rst_n ? w_ram_addr : 9'd0;
   assign bus.ram_wdata  = rst_n ? w_ram_wdata : 8'd0;

endmodule

// File: tb/tb_edid_update_ctrl.sv
// Directed plus randomized bench for edid_update_ctrl with a behavioural RAM
// image and checksum model.
module tb_edid_update_ctrl;

   logic cfg_clk = 1'b0;
   logic rst_n;
   logic hdmi_rx_5v_n;
   logic hpd;

   edid_update_ctrl_if bus();

   edid_update_ctrl #(
      .HPD_TIMEOUT_COUNT(32'd16),
      .HPD_LOW_CYCLES   (32'd8),
      .NUM_BLOCKS       (2),
      .I2C_WR_EN        (1'b0)
   ) dut (
      .cfg_clk     (cfg_clk),
      .rst_n       (rst_n),
      .hdmi_rx_5v_n(hdmi_rx_5v_n),
      .hpd         (hpd),
      .bus         (bus)
   );

   always #5 cfg_clk = ~cfg_clk;

   // EDID RAM with one-cycle read latency, plus a preload port for the bench
   logic [7:0] ram [0:511];
   logic       ld_we;
   logic [8:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] rd_q;

   always @(posedge cfg_clk) begin
      if (ld_we)
         ram[ld_addr] <= ld_data;
      else if (bus.ram_we)
         ram[bus.ram_addr] <= bus.ram_wdata;
      rd_q <= ram[bus.ram_addr];
   end
   assign bus.ram_rdata = rd_q;

   logic [7:0] exp_mem [0:511];
   int checks = 0;
   int errors = 0;

   task automatic chk1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge cfg_clk);
         #1;
      end
   endtask

   // one host byte write while granted; the model image follows it
   task automatic host_wr(input logic [8:0] a, input logic [7:0] d, input logic done);
      bus.host_we    = 1'b1;
      bus.host_addr  = a;
      bus.host_wdata = d;
      bus.host_done  = done;
      exp_mem[a]     = d;
      tick(1);
      bus.host_we   = 1'b0;
      bus.host_done = 1'b0;
   endtask

   // each block's last byte makes the 128-byte sum zero modulo 256
   task automatic model_csum();
      for (int b = 0; b < 2; b++) begin
         int s;
         s = 0;
         for (int i = 0; i < 127; i++)
            s = s + int'(exp_mem[b*128 + i]);
         exp_mem[b*128 + 127] = 8'((256 - (s % 256)) % 256);
      end
   endtask

   task automatic cmp_mem(input string tag);
      int d;
      d = 0;
      for (int i = 0; i < 512; i++)
         if (ram[i] !== exp_mem[i]) d++;
      chkn(tag, d, 0);
   endtask

   task automatic i2c_rd(input string tag, input logic [7:0] a);
      bus.i2c_addr = a;
      tick(1);
      chk8(tag, bus.i2c_rdata, exp_mem[{1'b0, a}]);
   endtask

   task automatic reset_outputs_zero(input string tag);
      chk1({tag, "_hpd"}, hpd, 1'b0);
      chk1({tag, "_busy"}, bus.upd_busy, 1'b0);
      chk1({tag, "_grant"}, bus.host_grant, 1'b0);
      chk1({tag, "_we"}, bus.ram_we, 1'b0);
      chkn({tag, "_addr"}, int'(bus.ram_addr), 0);
      chk8({tag, "_wdata"}, bus.ram_wdata, 8'h00);
   endtask

   initial begin
      logic [7:0] a;
      logic [7:0] v;

      rst_n          = 1'b0;
      hdmi_rx_5v_n   = 1'b1;
      bus.i2c_busy   = 1'b0;
      bus.i2c_addr   = 8'h5A;
      bus.i2c_wdata  = 8'hC3;
      bus.i2c_we     = 1'b0;
      bus.host_req   = 1'b0;
      bus.host_we    = 1'b0;
      bus.host_addr  = 9'h1A5;
      bus.host_wdata = 8'h77;
      bus.host_done  = 1'b0;
      ld_we          = 1'b0;
      ld_addr        = '0;
      ld_data        = '0;

      // random RAM image loaded under reset
      for (int i = 0; i < 512; i++) begin
         v          = 8'($urandom);
         ld_we      = 1'b1;
         ld_addr    = 9'(i);
         ld_data    = v;
         exp_mem[i] = v;
         tick(1);
      end
      ld_we = 1'b0;
      reset_outputs_zero("rst");

      // HPD qualification after reset release, then a one-cycle 5V dropout
      hdmi_rx_5v_n = 1'b0;
      rst_n        = 1'b1;
      tick(15);
      chk1("hpd_before_16", hpd, 1'b0);
      tick(1);
      chk1("hpd_at_16", hpd, 1'b1);
      hdmi_rx_5v_n = 1'b1;
      tick(1);
      chk1("hpd_5v_gone", hpd, 1'b0);
      hdmi_rx_5v_n = 1'b0;
      tick(15);
      chk1("hpd_requal_15", hpd, 1'b0);
      tick(1);
      chk1("hpd_requal_16", hpd, 1'b1);

      // IDLE: I2C reads served from RAM, I2C writes blocked
      for (int k = 0; k < 6; k++) begin
         a             = 8'($urandom);
         bus.i2c_we    = 1'b1;
         bus.i2c_wdata = 8'($urandom);
         bus.i2c_addr  = a;
         #1;
         chkn("idle_addr", int'(bus.ram_addr), int'({1'b0, a}));
         chk1("idle_i2c_we_blocked", bus.ram_we, 1'b0);
         tick(1);
         chk8("idle_i2c_rd", bus.i2c_rdata, exp_mem[{1'b0, a}]);
      end
      bus.i2c_we = 1'b0;

      // update request while an I2C transaction is in flight
      bus.i2c_busy = 1'b1;
      bus.host_req = 1'b1;
      tick(1);
      bus.host_req = 1'b0;
      chk1("drop_busy", bus.upd_busy, 1'b1);
      chk1("drop_hpd", hpd, 1'b0);
      chk1("drop_grant", bus.host_grant, 1'b0);
      chk8("drop_i2c_rd", bus.i2c_rdata, 8'hFF);
      bus.host_we    = 1'b1;
      bus.host_addr  = 9'd5;
      bus.host_wdata = 8'hAA;
      bus.i2c_we     = 1'b1;
      #1;
      chk1("drop_we_ignored", bus.ram_we, 1'b0);
      tick(9);
      bus.host_we = 1'b0;
      bus.i2c_we  = 1'b0;
      chk1("drop_grant_held", bus.host_grant, 1'b0);
      bus.i2c_busy = 1'b0;
      tick(1);
      chk1("host_grant", bus.host_grant, 1'b1);

      // fixed pattern: block 0 = 0x01, block 1 = 0x00, stale byte 127
      for (int i = 0; i < 256; i++)
         host_wr(9'(i), (i < 127) ? 8'h01 : ((i == 127) ? 8'h33 : 8'h00), i == 255);
      model_csum();
      chk1("csum_grant", bus.host_grant, 1'b0);
      chk1("csum_busy", bus.upd_busy, 1'b1);
      chk1("csum_hpd", hpd, 1'b0);
      tick(100);
      chk8("csum_i2c_rd", bus.i2c_rdata, 8'hFF);
      bus.host_req = 1'b1;
      tick(1);
      bus.host_req = 1'b0;
      tick(164);
      chk1("busy_last_cycle", bus.upd_busy, 1'b1);
      tick(1);
      chk1("busy_fall", bus.upd_busy, 1'b0);
      chk1("hpd_after_update", hpd, 1'b1);
      chk8("csum_addr127", ram[127], 8'h81);
      chk8("csum_addr255", ram[255], 8'h00);
      cmp_mem("mem_after_fixed");
      i2c_rd("i2c_rd_127", 8'd127);

      // host strobes in IDLE have no effect
      bus.host_done = 1'b1;
      bus.host_we   = 1'b1;
      #1;
      chk1("idle_host_we", bus.ram_we, 1'b0);
      tick(1);
      chk1("idle_host_done", bus.upd_busy, 1'b0);
      bus.host_done = 1'b0;
      bus.host_we   = 1'b0;

      // random contents with 5V flickering during the update
      bus.host_req = 1'b1;
      tick(1);
      bus.host_req = 1'b0;
      chk1("drop1_grant", bus.host_grant, 1'b0);
      tick(1);
      chk1("drop1_exit", bus.host_grant, 1'b1);
      for (int i = 0; i < 256; i++) begin
         hdmi_rx_5v_n = 1'($urandom);
         host_wr(9'(i), 8'($urandom), i == 255);
      end
      hdmi_rx_5v_n = 1'b0;
      model_csum();
      tick(266);
      chk1("rand_busy_fall", bus.upd_busy, 1'b0);
      chk1("rand_hpd", hpd, 1'b1);
      cmp_mem("mem_after_random");
      for (int k = 0; k < 4; k++)
         i2c_rd("rand_i2c_rd", 8'($urandom));

      // reset during the checksum pass abandons it
      bus.host_req = 1'b1;
      tick(1);
      bus.host_req = 1'b0;
      tick(1);
      for (int i = 0; i < 256; i++)
         host_wr(9'(i), 8'($urandom), i == 255);
      tick(60);
      rst_n = 1'b0;
      #1;
      reset_outputs_zero("midcsum");
      tick(2);
      rst_n = 1'b1;
      tick(15);
      chk1("hpd_after_rst_15", hpd, 1'b0);
      tick(1);
      chk1("hpd_after_rst_16", hpd, 1'b1);
      tick(300);
      chk8("no_csum_127", ram[127], exp_mem[127]);
      chk8("no_csum_255", ram[255], exp_mem[255]);
      cmp_mem("mem_after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
